// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard.
// Holds the operand forward-select encodings, the zero-register constant,
// the pipeline destination tag record and the multiply tracker state type.
package hazard_scoreboard_pkg;

    // Operand source selects for the instruction in EX
    localparam logic [0:1] FWD_REG = 2'b00;
    localparam logic [0:1] FWD_MEM = 2'b10;
    localparam logic [0:1] FWD_WB  = 2'b11;

    // Register 0 never carries a dependency
    localparam logic [0:5] ZERO_REG = 6'd0;

    // Destination tag carried down EX -> MEM -> WB.
    // valid is only set for instructions that actually write a register.
    typedef struct packed {
        logic       valid;
        logic       isLoad;
        logic [0:5] addr;
    } PipeTag;

    localparam PipeTag BUBBLE_TAG = '0;

    typedef enum logic {
        MUL_IDLE,
        MUL_BUSY
    } MulState;

    // A tag can only create a dependency when it is live and not r0
    function automatic logic producesHazard(input PipeTag tag);
        return tag.valid && (tag.addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mul_tracker.sv
// Multicycle unit tracker: counts down the multiply latency, then requests
// the shared regfile write port and waits for a free WB slot.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start, startAddr  accepted multiply issue and its destination
//   wbValid           pipeline WB stage owns the write port this cycle
//   mulWE             write port granted to the multiply result this cycle
//   mulWAddr          destination of the in-flight multiply
//   mulBusy           multicycle unit occupied
module mul_tracker
    import hazard_scoreboard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [0:5] startAddr,
    input  logic       wbValid,
    output logic       mulWE,
    output logic [0:5] mulWAddr,
    output logic       mulBusy
);

    MulState    state;
    MulState    stateNext;
    logic [3:0] count;
    logic [3:0] countNext;
    logic [0:5] addrNext;

    // State, countdown and destination registers; reset drops any
    // in-flight multiply without ever producing a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MUL_IDLE;
            count    <= '0;
            mulWAddr <= ZERO_REG;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            mulWAddr <= addrNext;
        end
    end

    // Count down to 1, then hold at 1 until WB leaves the write port free;
    // the granted cycle is the last busy cycle.
    always_comb begin
        stateNext = state;
        countNext = count;
        addrNext  = mulWAddr;
        mulWE     = 1'b0;
        case (state)
            MUL_IDLE: begin
                if (start) begin
                    stateNext = MUL_BUSY;
                    countNext = 4'(MUL_LAT);
                    addrNext  = startAddr;
                end
            end
            MUL_BUSY: begin
                if (count > 4'd1) begin
                    countNext = count - 4'd1;
                end else if (!wbValid) begin
                    mulWE     = 1'b1;
                    stateNext = MUL_IDLE;
                    countNext = '0;
                end
            end
            default: begin
                stateNext = MUL_IDLE;
            end
        endcase
    end

    assign mulBusy = (state == MUL_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: detects load-use and multicycle hazards at
// decode, produces registered forwarding selects for EX, and arbitrates the
// regfile write port between the pipeline and the multicycle unit.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   IssueValid/IsLoad/IsMul    decode instruction qualifiers
//   IssueRs1/Rs2, IssueUse1/2  source addresses and whether they are read
//   IssueRegWE, IssueWAddr     destination write enable and address
//   Stall                      hold decode/fetch (combinational)
//   FwdA, FwdB                 registered operand selects for EX
//   MulWE, MulWAddr, MulBusy   multicycle unit write grant and status
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       IssueValid,
    input  logic       IssueIsLoad,
    input  logic       IssueIsMul,
    input  logic [0:5] IssueRs1,
    input  logic [0:5] IssueRs2,
    input  logic       IssueUse1,
    input  logic       IssueUse2,
    input  logic       IssueRegWE,
    input  logic [0:5] IssueWAddr,
    output logic       Stall,
    output logic [0:1] FwdA,
    output logic [0:1] FwdB,
    output logic       MulWE,
    output logic [0:5] MulWAddr,
    output logic       MulBusy
);

    PipeTag     exTag;
    PipeTag     memTag;
    PipeTag     wbTag;
    PipeTag     issueTag;
    logic       loadUseStall;
    logic       mulStall;
    logic       acceptPipe;
    logic       acceptMul;
    logic [0:1] fwdANext;
    logic [0:1] fwdBNext;
    logic       unusedWbFields;

    // Younger EX result wins; a load in EX cannot forward yet (that case
    // stalls instead). WB is covered by the regfile bypass.
    function automatic logic [0:1] selectFwd(input logic [0:5] src,
                                             input PipeTag ex,
                                             input PipeTag mem);
        if (producesHazard(ex) && !ex.isLoad && (src == ex.addr))
            return FWD_MEM;
        else if (producesHazard(mem) && (src == mem.addr))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    // Hazard detection at decode and issue acceptance
    always_comb begin
        loadUseStall = producesHazard(exTag) && exTag.isLoad &&
                       ((IssueUse1 && (IssueRs1 == exTag.addr)) ||
                        (IssueUse2 && (IssueRs2 == exTag.addr)));
        mulStall     = MulBusy &&
                       (IssueIsMul ||
                        (IssueUse1 && (IssueRs1 == MulWAddr)) ||
                        (IssueUse2 && (IssueRs2 == MulWAddr)) ||
                        (IssueRegWE && (IssueWAddr == MulWAddr)));
        Stall        = IssueValid && (loadUseStall || mulStall);
        acceptPipe   = IssueValid && !Stall && !IssueIsMul;
        acceptMul    = IssueValid && !Stall && IssueIsMul;

        issueTag        = BUBBLE_TAG;
        issueTag.valid  = acceptPipe && IssueRegWE;
        issueTag.isLoad = IssueIsLoad;
        issueTag.addr   = IssueWAddr;

        fwdANext = FWD_REG;
        fwdBNext = FWD_REG;
        if (acceptPipe) begin
            fwdANext = selectFwd(IssueRs1, exTag, memTag);
            fwdBNext = selectFwd(IssueRs2, exTag, memTag);
        end
    end

    // Tag shift register; MEM and WB keep moving during a stall so that
    // the producer always drains and the stall resolves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exTag  <= BUBBLE_TAG;
            memTag <= BUBBLE_TAG;
            wbTag  <= BUBBLE_TAG;
            FwdA   <= FWD_REG;
            FwdB   <= FWD_REG;
        end else begin
            exTag  <= issueTag;
            memTag <= exTag;
            wbTag  <= memTag;
            FwdA   <= fwdANext;
            FwdB   <= fwdBNext;
        end
    end

    // Only the WB valid bit matters for write-port arbitration
    assign unusedWbFields = ^{wbTag.isLoad, wbTag.addr};

    mul_tracker #(
        .MUL_LAT (MUL_LAT)
    ) mulTracker (
        .clk       (clk),
        .reset     (reset),
        .start     (acceptMul),
        .startAddr (IssueWAddr),
        .wbValid   (wbTag.valid),
        .mulWE     (MulWE),
        .mulWAddr  (MulWAddr),
        .mulBusy   (MulBusy)
    );

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter: MUL_LAT, 4, cycles from multiply issue to earliest writeback request (legal range 2..15).
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: IssueValid  in  1  decode holds a valid instruction; IssueIsLoad  in  1  instruction is a load; IssueIsMul  in  1  instruction goes to the multicycle unit.
REQ-005 SHALL have ports: IssueRs1, IssueRs2  in  6 each ([0:5])  source addresses, bit 0 = FP bank; IssueUse1, IssueUse2  in  1 each  source actually read.
REQ-006 SHALL have ports: IssueRegWE  in  1  instruction writes a register; IssueWAddr  in  6 ([0:5])  destination.
REQ-007 SHALL have port: Stall  out  1  hold decode/fetch this cycle; combinational.
REQ-008 SHALL have ports: FwdA, FwdB  out  2 each ([0:1])  registered operand-source selects for the instruction now in EX: 00 regfile, 10 MEM-stage data, 11 WB-stage data (01 unused).
REQ-009 SHALL have ports: MulWE  out  1  multiply result granted the regfile write port this cycle; MulWAddr  out  6  its destination; MulBusy  out  1  multicycle unit occupied.

Function
REQ-010 SHALL keep three destination tags EX, MEM, WB, each {valid, is_load, addr[0:5]}.
REQ-011 SHALL, each edge, shift WB<=MEM, MEM<=EX, and EX<=issue tag when IssueValid & !Stall & !IssueIsMul, else EX<=bubble (valid=0).
REQ-012 SHALL treat a tag as hazard-producing only when valid, its instruction writes a register, and addr != 6'd0.
REQ-013 SHALL assert Stall (load-use) when EX tag is a load and an used source equals EX.addr; exactly one stall cycle results.
REQ-014 SHALL, on accepted non-mul issue, register FwdX = 10 if source matches a non-load EX tag, else 11 if it matches MEM tag, else 00; the younger (EX) match wins; a non-issue cycle loads 00.
REQ-015 SHALL not forward from the WB tag (decode regfile bypass covers it).
REQ-016 SHALL, on accepted mul issue, set MulBusy=1, load counter with MUL_LAT, latch destination into MulWAddr.
REQ-017 SHALL decrement the counter each cycle while above 1; at 1 request the write port.
REQ-018 SHALL grant the write port (MulWE=1 for one cycle) only when the WB tag is not valid; pipeline WB has priority, counter holds at 1 while denied.
REQ-019 SHALL clear MulBusy on the edge ending the granted cycle.
REQ-020 SHALL assert Stall while MulBusy when: IssueIsMul (structural), an used source equals MulWAddr (RAW), or IssueRegWE with IssueWAddr equal to MulWAddr (WAW).
REQ-021 SHALL evaluate hazards only when IssueValid; Stall=0 otherwise.
REQ-022 SHALL keep MEM/WB shifting during Stall so stalls always resolve.

Reset
REQ-023 SHALL on reset clear all tags to invalid, counter to 0, MulBusy/MulWE to 0, MulWAddr to 0, FwdA/FwdB to 00, independent of clk.
REQ-024 SHALL abandon an in-flight multiply on reset mid-operation with no MulWE pulse.

Structure
REQ-025 SHALL place forward-select encodings (REG=00, MEM=10, WB=11), the zero-register constant, and the tag record layout in the shared pipeline package.
REQ-026 SHALL implement the multiply counter/arbiter as one sub-module, mul_tracker; tag shift and compare logic stay in the top.

Verification
REQ-027 SHALL test: load r5 then add using r5 -> Stall=1 one cycle, then FwdA=11 with add in EX.
REQ-028 SHALL test: add r3, then sub reading r3 and r3 -> no stall, FwdA=FwdB=10; one independent instruction between -> 11.
REQ-029 SHALL test: mul to r7 (MUL_LAT=4), reader of r7 next cycle -> Stall held until cycle after MulWE pulse; MulWAddr=7.
REQ-030 SHALL test: mul completing while a WB tag is valid each cycle for 2 cycles -> MulWE delayed exactly 2 cycles, single pulse.
REQ-031 SHALL test: write to r0 followed by reader of r0 -> no stall, Fwd=00.
REQ-032 SHALL test: reset asserted at counter=2 -> MulBusy=0 immediately, no MulWE afterward, outputs at reset values.
